// File: rtl/redmule_tile_sequencer_if.sv
// Request/handshake bundle between the tile sequencer, the job register file
// and the streamer/engine side.
interface redmule_tile_sequencer_if #(
  parameter int unsigned ITER_W = 16
) ();
  logic              start_i;
  logic [ITER_W-1:0] m_iters_i;
  logic [ITER_W-1:0] k_iters_i;
  logic [ITER_W-1:0] n_iters_i;
  logic              y_en_valid_i;
  logic              y_en_i;
  logic              x_req_valid_o;
  logic              x_req_ready_i;
  logic              w_req_valid_o;
  logic              w_req_ready_i;
  logic              y_req_valid_o;
  logic              y_req_ready_i;
  logic              engine_done_i;
  logic              z_store_valid_o;
  logic              z_store_ready_i;
  logic [ITER_W-1:0] m_idx_o;
  logic [ITER_W-1:0] k_idx_o;
  logic [ITER_W-1:0] n_idx_o;
  logic              last_m_o;
  logic              last_k_o;
  logic              last_n_o;
  logic              busy_o;
  logic              done_o;

  // Sequencer side.
  modport master (
    input  start_i, m_iters_i, k_iters_i, n_iters_i, y_en_valid_i, y_en_i,
    input  x_req_ready_i, w_req_ready_i, y_req_ready_i, engine_done_i, z_store_ready_i,
    output x_req_valid_o, w_req_valid_o, y_req_valid_o, z_store_valid_o,
    output m_idx_o, k_idx_o, n_idx_o, last_m_o, last_k_o, last_n_o, busy_o, done_o
  );

  // Job/streamer/engine side.
  modport slave (
    output start_i, m_iters_i, k_iters_i, n_iters_i, y_en_valid_i, y_en_i,
    output x_req_ready_i, w_req_ready_i, y_req_ready_i, engine_done_i, z_store_ready_i,
    input  x_req_valid_o, w_req_valid_o, y_req_valid_o, z_store_valid_o,
    input  m_idx_o, k_idx_o, n_idx_o, last_m_o, last_k_o, last_n_o, busy_o, done_o
  );
endinterface

// File: rtl/redmule_tile_sequencer.sv
// Walks the M/K/N tile loop nest of one RedMulE job: issues X/W/Y loads per
// inner tile, waits for the engine, and stores Z once per (m,k) output tile.
module redmule_tile_sequencer #(
  parameter int unsigned ITER_W       = 16,
  parameter bit          Y_EN_DEFAULT = 1'b1
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  input logic                      clear_i,
  redmule_tile_sequencer_if.master bus
);

  localparam logic [ITER_W-1:0] One = ITER_W'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitEng, StStore, StDone} state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] m_iters_q, m_iters_d, k_iters_q, k_iters_d, n_iters_q, n_iters_d;
  logic [ITER_W-1:0] m_idx_q, m_idx_d, k_idx_q, k_idx_d, n_idx_q, n_idx_d;
  logic              y_en_q, y_en_d;
  logic              x_pend_q, x_pend_d, w_pend_q, w_pend_d, y_pend_q, y_pend_d;
  logic              last_m, last_k, last_n;
  logic              x_left, w_left, y_left, enter_load;

  assign last_m = (m_idx_q == m_iters_q - One);
  assign last_k = (k_idx_q == k_iters_q - One);
  assign last_n = (n_idx_q == n_iters_q - One);

  // Next-state, loop-index and per-stream pending-request logic.
  always_comb begin
    state_d    = state_q;
    m_iters_d  = m_iters_q;
    k_iters_d  = k_iters_q;
    n_iters_d  = n_iters_q;
    m_idx_d    = m_idx_q;
    k_idx_d    = k_idx_q;
    n_idx_d    = n_idx_q;
    y_en_d     = y_en_q;
    x_pend_d   = x_pend_q;
    w_pend_d   = w_pend_q;
    y_pend_d   = y_pend_q;
    enter_load = 1'b0;
    // A request still outstanding after this cycle's possible handshake.
    x_left     = x_pend_q & ~bus.x_req_ready_i;
    w_left     = w_pend_q & ~bus.w_req_ready_i;
    y_left     = y_pend_q & ~bus.y_req_ready_i;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          // A zero count still runs one tile.
          m_iters_d  = (bus.m_iters_i == '0) ? One : bus.m_iters_i;
          k_iters_d  = (bus.k_iters_i == '0) ? One : bus.k_iters_i;
          n_iters_d  = (bus.n_iters_i == '0) ? One : bus.n_iters_i;
          y_en_d     = bus.y_en_valid_i ? bus.y_en_i : Y_EN_DEFAULT;
          m_idx_d    = '0;
          k_idx_d    = '0;
          n_idx_d    = '0;
          enter_load = 1'b1;
        end
      end
      StLoad: begin
        x_pend_d = x_left;
        w_pend_d = w_left;
        y_pend_d = y_left;
        if (!x_left && !w_left && !y_left) state_d = StWaitEng;
      end
      StWaitEng: begin
        if (bus.engine_done_i) begin
          if (!last_n) begin
            n_idx_d    = n_idx_q + One;
            enter_load = 1'b1;
          end else begin
            state_d = StStore;
          end
        end
      end
      StStore: begin
        if (bus.z_store_ready_i) begin
          n_idx_d = '0;
          if (!last_k) begin
            k_idx_d    = k_idx_q + One;
            enter_load = 1'b1;
          end else if (!last_m) begin
            k_idx_d    = '0;
            m_idx_d    = m_idx_q + One;
            enter_load = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (enter_load) begin
      state_d  = StLoad;
      x_pend_d = 1'b1;
      w_pend_d = 1'b1;
      // Y is only needed to seed the accumulator on the first inner tile.
      y_pend_d = y_en_d && (n_idx_d == '0);
    end
  end

  // State registers with synchronous reset and soft clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q   <= StIdle;
      m_iters_q <= '0;
      k_iters_q <= '0;
      n_iters_q <= '0;
      m_idx_q   <= '0;
      k_idx_q   <= '0;
      n_idx_q   <= '0;
      y_en_q    <= 1'b0;
      x_pend_q  <= 1'b0;
      w_pend_q  <= 1'b0;
      y_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_iters_q <= m_iters_d;
      k_iters_q <= k_iters_d;
      n_iters_q <= n_iters_d;
      m_idx_q   <= m_idx_d;
      k_idx_q   <= k_idx_d;
      n_idx_q   <= n_idx_d;
      y_en_q    <= y_en_d;
      x_pend_q  <= x_pend_d;
      w_pend_q  <= w_pend_d;
      y_pend_q  <= y_pend_d;
    end
  end

  assign bus.x_req_valid_o   = x_pend_q;
  assign bus.w_req_valid_o   = w_pend_q;
  assign bus.y_req_valid_o   = y_pend_q;
  assign bus.z_store_valid_o = (state_q == StStore);
  assign bus.m_idx_o         = m_idx_q;
  assign bus.k_idx_o         = k_idx_q;
  assign bus.n_idx_o         = n_idx_q;
  assign bus.last_m_o        = last_m;
  assign bus.last_k_o        = last_k;
  assign bus.last_n_o        = last_n;
  assign bus.busy_o          = (state_q != StIdle);
  assign bus.done_o          = (state_q == StDone);

endmodule

// File: doc/redmule_tile_sequencer.md
Name: redmule_tile_sequencer

Overview:
- Walks the GEMM tile loop nest (row tiles M, output-column tiles K, inner tiles N) for one RedMulE job.
- Issues X/W/Y tile-load requests and Z tile-store requests to the streamer/buffer control.
- Waits for a per-tile engine completion pulse before advancing.
- Sits between the job register file (iteration counts) and the scheduler/streamer FSMs.

Parameters:
ITER_W, 16, width of every iteration count and tile index
Y_EN_DEFAULT, 1, value of y_en used when y_en_valid_i is low at start

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
clear_i  input  1  synchronous soft clear, same effect as reset
start_i  input  1  job start pulse; sampled only in IDLE
m_iters_i  input  ITER_W  number of row tiles (X/Y rows)
k_iters_i  input  ITER_W  number of output column tiles (W/Z cols)
n_iters_i  input  ITER_W  number of inner tiles (X cols / W rows)
y_en_valid_i  input  1  y_en_i is meaningful
y_en_i  input  1  accumulate Y (1) or start from zero (0)
x_req_valid_o  output  1  X tile load request
x_req_ready_i  input  1  X request accepted
w_req_valid_o  output  1  W tile load request
w_req_ready_i  input  1  W request accepted
y_req_valid_o  output  1  Y tile load request
y_req_ready_i  input  1  Y request accepted
engine_done_i  input  1  one-cycle pulse: current inner tile consumed by array
z_store_valid_o  output  1  Z tile store request
z_store_ready_i  input  1  Z store accepted
m_idx_o  output  ITER_W  current row tile index
k_idx_o  output  ITER_W  current column tile index
n_idx_o  output  ITER_W  current inner tile index
last_m_o  output  1  m_idx_o == m_iters-1
last_k_o  output  1  k_idx_o == k_iters-1
last_n_o  output  1  n_idx_o == n_iters-1
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse at job end

Behaviour:
- Reset/clear: state IDLE; all indices 0; all valid outputs 0; busy_o 0; done_o 0; latched iteration counts 0.
- Clear has priority over all other inputs, including mid-handshake; any valid in flight is dropped.
- IDLE + start_i: latch m/k/n iters. A latched count of 0 is stored as 1. Latch y_en (y_en_i if y_en_valid_i, else Y_EN_DEFAULT). Indices go to 0. Next state is LOAD.
- start_i outside IDLE is ignored.
- LOAD:
  - x_req_valid_o and w_req_valid_o rise on LOAD entry.
  - y_req_valid_o rises on LOAD entry only when n_idx==0 and y_en=1.
  - Each valid drops the cycle after its own valid&ready handshake. A pending bit per stream tracks this; valids never re-assert within one LOAD visit.
  - When all required handshakes are done, move to WAIT_ENG. Same-cycle accept of the last request counts as done.
- WAIT_ENG: on engine_done_i:
  - if not last_n: n_idx+1, go to LOAD.
  - if last_n: go to STORE.
  - engine_done_i in any other state is ignored.
- STORE: z_store_valid_o=1 until handshake. On handshake, n_idx returns to 0, then:
  - if not last_k: k_idx+1, go to LOAD.
  - else if not last_m: k_idx returns to 0, m_idx+1, go to LOAD.
  - else: go to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o still 1; next state IDLE. Indices hold their final values until the next start.
- Index outputs and last_* are registered/decoded from state registers. They stay stable while any valid is high.
- Valid/ready rule: once asserted, a valid never drops before its handshake (except clear/reset).
- Index arithmetic is ITER_W wide. Wrap is impossible because counts are at most 2^ITER_W-1 and indices stop at count-1.
- Latency per inner tile, with zero-wait ready and an immediate engine pulse: LOAD 1 cycle + WAIT_ENG 1 cycle.
- Total job = M*K*(N*2 + 1) + 1 cycles, excluding the start cycle.

Test Plan:
- Basic nest: M=2, K=3, N=4, y_en=1, all ready=1, engine_done 1 cycle after LOAD -> 24 X and 24 W handshakes, 6 Y (only at n=0), 6 Z stores in order (m,k)=(0,0),(0,1),(0,2),(1,0)..(1,2); done_o a single pulse; busy_o low next cycle.
- Backpressure: x_req_ready_i held low 5 cycles, w ready immediate -> w_req_valid_o drops after 1 cycle, x_req_valid_o and indices stable 5 cycles, no WAIT_ENG entry before X accepted.
- Zero counts: M=0, K=0, N=0 -> treated as 1: exactly one X, W, Z handshake; last_m/k/n all 1; done_o pulse.
- y_en_valid_i=0 with Y_EN_DEFAULT=0 -> y_req_valid_o never asserts through the job.
- Clear mid-STORE (z_store_ready_i=0, clear_i at cycle 40) -> next cycle IDLE, all valids 0, indices 0, no done_o; new start runs a full job correctly.
- Spurious inputs: start_i and engine_done_i pulsed during LOAD -> ignored; counts unchanged; sequence identical to the basic-nest reference.
